// File: rtl/sw_event_arbiter.sv
// Switch-edge event arbiter: turns debounced switch transitions into a stream of
// press/release events, served round-robin and handed off with a valid/ready handshake.
module sw_event_arbiter #(
    parameter bit EN_RELEASE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] SW_db,
    input  logic        ev_ready,
    input  logic        ovf_clr,
    output logic        ev_valid,
    output logic [4:0]  ev_idx,
    output logic        ev_level,
    output logic        ovf,
    output logic [15:0] ev_count,
    output logic        busy
);
    // state      | meaning
    // ST_IDLE    | nothing presented; grant the next requesting line
    // ST_PRESENT | event held on ev_idx/ev_level until ev_ready
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESENT = 2'b01
    } state_t;

    localparam int         NLINES    = 18;
    localparam logic [4:0] LAST_LINE = 5'd17;

    state_t      state_q, state_d;
    logic [17:0] sw_q;
    logic [17:0] pend_p_q, pend_p_d, pend_r_q, pend_r_d;
    logic [17:0] rise, fall, req, clr_p, clr_r, keep_p, keep_r;
    logic        ovf_q, ovf_d, ovf_set;
    logic [4:0]  ev_idx_q, ev_idx_d;
    logic        ev_level_q, ev_level_d;
    logic [4:0]  last_grant_q, last_grant_d;
    logic [15:0] ev_count_q, ev_count_d;
    logic [4:0]  gnt_idx;
    logic        gnt_found, gnt_level;
    logic [5:0]  cand;

    assign rise = SW_db & ~sw_q;
    assign fall = EN_RELEASE ? (~SW_db & sw_q) : 18'd0;
    assign req  = pend_p_q | pend_r_q;

    // Round-robin search starting one past the last granted line.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 5'd0;
        cand      = 6'd0;
        for (int k = 1; k <= NLINES; k++) begin
            cand = {1'b0, last_grant_q} + 6'(k);
            if (cand >= 6'(NLINES)) begin
                cand = cand - 6'(NLINES);
            end
            if (!gnt_found && req[cand[4:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[4:0];
            end
        end
    end

    // With both edges pending, the current level tells which came last.
    always_comb begin
        if (pend_p_q[gnt_idx] && pend_r_q[gnt_idx]) begin
            gnt_level = ~sw_q[gnt_idx];
        end else begin
            gnt_level = pend_p_q[gnt_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        ev_idx_d     = ev_idx_q;
        ev_level_d   = ev_level_q;
        last_grant_d = last_grant_q;
        ev_count_d   = ev_count_q;
        clr_p        = 18'd0;
        clr_r        = 18'd0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    ev_idx_d       = gnt_idx;
                    ev_level_d     = gnt_level;
                    last_grant_d   = gnt_idx;
                    clr_p[gnt_idx] = gnt_level;
                    clr_r[gnt_idx] = ~gnt_level;
                    state_d        = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ev_ready) begin
                    ev_count_d = ev_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear-by-grant happens before the new edge is merged, so a fresh edge survives.
    always_comb begin
        keep_p   = pend_p_q & ~clr_p;
        keep_r   = pend_r_q & ~clr_r;
        ovf_set  = (|(rise & keep_p)) | (|(fall & keep_r));
        pend_p_d = keep_p | rise;
        pend_r_d = keep_r | fall;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sw_q         <= 18'd0;
            pend_p_q     <= 18'd0;
            pend_r_q     <= 18'd0;
            ovf_q        <= 1'b0;
            ev_idx_q     <= 5'd0;
            ev_level_q   <= 1'b0;
            last_grant_q <= LAST_LINE;
            ev_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            sw_q         <= SW_db;
            pend_p_q     <= pend_p_d;
            pend_r_q     <= pend_r_d;
            ovf_q        <= ovf_d;
            ev_idx_q     <= ev_idx_d;
            ev_level_q   <= ev_level_d;
            last_grant_q <= last_grant_d;
            ev_count_q   <= ev_count_d;
        end
    end

    assign ev_valid = (state_q == ST_PRESENT);
    assign ev_idx   = ev_idx_q;
    assign ev_level = ev_level_q;
    assign ovf      = ovf_q;
    assign ev_count = ev_count_q;
    assign busy     = ev_valid | (|pend_p_q) | (|pend_r_q);

endmodule
